// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// MEM-stage data-memory sequencer. Presents one registered req/ack access per
// load/store, freezes the pipeline with mem_stall while the access is open,
// aborts accesses that exceed TIMEOUT busy cycles, and keeps a saturating
// count of stalled cycles.
module dmem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              dm_ack,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    output logic              mem_stall,
    output logic [DATA_W-1:0] rdata_out,
    output logic              timeout_err,
    output logic [PERF_W-1:0] stall_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Last busy-cycle index before the access is abandoned.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]      state;
    logic [TO_W-1:0] to_cnt;
    logic            access;

    assign access = mem_read | mem_write;

    // Stall the pipeline from the cycle the access appears until the ack (or abort); held low in reset.
    always_comb begin
        mem_stall = rst_n && (((state == ST_IDLE) && access) || (state == ST_BUSY));
    end

    // Access sequencer: latch the request, wait for ack or timeout, then release for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            dm_req      <= 1'b0;
            dm_we       <= 1'b0;
            dm_addr     <= '0;
            dm_wdata    <= '0;
            rdata_out   <= '0;
            timeout_err <= 1'b0;
            to_cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        dm_addr  <= addr;
                        dm_wdata <= wdata;
                        dm_we    <= mem_write;
                        dm_req   <= 1'b1;
                        to_cnt   <= '0;
                        state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (dm_ack) begin
                        if (!dm_we) begin
                            rdata_out <= dm_rdata;
                        end
                        dm_req <= 1'b0;
                        state  <= ST_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        dm_req      <= 1'b0;
                        timeout_err <= 1'b1;
                        if (!dm_we) begin
                            rdata_out <= '1;
                        end
                        state <= ST_DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Performance counter of stalled cycles, pinned at all-ones once full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (mem_stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl
// Drives directed and random load/store transactions into two instances
// (wide and 2-bit stall counters) and compares every output each cycle with a
// transaction-level model of the access sequencer.
module tb_dmem_access_ctrl;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    logic        dm_req, dm_we, mem_stall, timeout_err;
    logic [31:0] dm_addr, dm_wdata, rdata_out;
    logic [15:0] stall_cnt;

    logic        s_dm_req, s_dm_we, s_mem_stall, s_timeout_err;
    logic [31:0] s_dm_addr, s_dm_wdata, s_rdata_out;
    logic [1:0]  s_stall_cnt;

    int checks = 0;
    int errors = 0;

    // Transaction-level model state
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_we, m_err;
    int          m_cnt;

    dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .TO_W(8), .PERF_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .mem_stall(mem_stall), .rdata_out(rdata_out), .timeout_err(timeout_err),
        .stall_cnt(stall_cnt)
    );

    dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .TO_W(8), .PERF_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .dm_req(s_dm_req), .dm_we(s_dm_we), .dm_addr(s_dm_addr), .dm_wdata(s_dm_wdata),
        .mem_stall(s_mem_stall), .rdata_out(s_rdata_out), .timeout_err(s_timeout_err),
        .stall_cnt(s_stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] sat(input int c, input int w);
        int mx;
        mx = (1 << w) - 1;
        return 64'((c > mx) ? mx : c);
    endfunction

    task automatic checkOne(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_addr  = '0;
        m_wdata = '0;
        m_rdata = '0;
        m_we    = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 0;
    endtask

    // Compare every output of both instances against the model for this cycle
    task automatic checkOutput(input logic e_stall, input logic e_req);
        checkOne("mem_stall",     64'(mem_stall),     64'(e_stall));
        checkOne("dm_req",        64'(dm_req),        64'(e_req));
        checkOne("dm_we",         64'(dm_we),         64'(m_we));
        checkOne("dm_addr",       64'(dm_addr),       64'(m_addr));
        checkOne("dm_wdata",      64'(dm_wdata),      64'(m_wdata));
        checkOne("rdata_out",     64'(rdata_out),     64'(m_rdata));
        checkOne("timeout_err",   64'(timeout_err),   64'(m_err));
        checkOne("stall_cnt",     64'(stall_cnt),     sat(m_cnt, 16));
        checkOne("s_mem_stall",   64'(s_mem_stall),   64'(e_stall));
        checkOne("s_dm_req",      64'(s_dm_req),      64'(e_req));
        checkOne("s_dm_we",       64'(s_dm_we),       64'(m_we));
        checkOne("s_dm_addr",     64'(s_dm_addr),     64'(m_addr));
        checkOne("s_dm_wdata",    64'(s_dm_wdata),    64'(m_wdata));
        checkOne("s_rdata_out",   64'(s_rdata_out),   64'(m_rdata));
        checkOne("s_timeout_err", 64'(s_timeout_err), 64'(m_err));
        checkOne("s_stall_cnt",   64'(s_stall_cnt),   sat(m_cnt, 2));
        if (e_stall) m_cnt++;
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [31:0] wd, input logic ack, input logic [31:0] rdat);
        @(negedge clk);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        dm_ack    = ack;
        dm_rdata  = rdat;
        #1;
    endtask

    // One full access; ack_at = busy cycle carrying the ack, 0 or >TIMEOUT = never
    task automatic runAccess(input bit is_write, input logic [31:0] a, input logic [31:0] wd,
                             input int ack_at, input logic [31:0] rd);
        bit acked;
        int busy;
        acked = (ack_at >= 1) && (ack_at <= TIMEOUT);
        busy  = acked ? ack_at : TIMEOUT;
        applyStimulus(!is_write, is_write, a, wd, 1'b0, $urandom);
        checkOutput(1'b1, 1'b0);
        m_addr  = a;
        m_wdata = wd;
        m_we    = is_write;
        for (int k = 1; k <= busy; k++) begin
            if (acked && k == ack_at)
                applyStimulus(!is_write, is_write, a, wd, 1'b1, rd);
            else
                applyStimulus(!is_write, is_write, a, wd, 1'b0, $urandom);
            checkOutput(1'b1, 1'b1);
        end
        if (!is_write) m_rdata = acked ? rd : 32'hFFFF_FFFF;
        if (!acked) m_err = 1'b1;
        applyStimulus(!is_write, is_write, a, wd, 1'($urandom_range(0, 1)), $urandom);
        checkOutput(1'b0, 1'b0);
    endtask

    task automatic idleCycles(input int n, input logic force_ack);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, $urandom, $urandom,
                          force_ack | 1'($urandom_range(0, 1)), $urandom);
            checkOutput(1'b0, 1'b0);
        end
    endtask

    initial begin
        int base;
        modelReset();
        rst_n     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = '0;
        wdata     = '0;
        dm_ack    = 1'b0;
        dm_rdata  = '0;
        #2;
        checkOutput(1'b0, 1'b0);
        mem_read = 1'b1;
        #1;
        checkOutput(1'b0, 1'b0);
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(2, 1'b0);

        $display("[TB] load with ack in third busy cycle");
        runAccess(1'b0, 32'h40, 32'h0, 3, 32'h1234_5678);
        checkOne("t1_rdata", 64'(rdata_out), 64'h1234_5678);
        checkOne("t1_stall_cnt", 64'(stall_cnt), 64'd4);
        checkOne("t1_sat_cnt", 64'(s_stall_cnt), 64'd3);

        $display("[TB] store with ack in first busy cycle");
        base = m_cnt;
        runAccess(1'b1, 32'h80, 32'hCAFE, 1, 32'hDEAD_BEEF);
        checkOne("t2_rdata_kept", 64'(rdata_out), 64'h1234_5678);
        checkOne("t2_dm_wdata", 64'(dm_wdata), 64'hCAFE);
        checkOne("t2_dm_we", 64'(dm_we), 64'd1);
        checkOne("t2_stall_delta", 64'(stall_cnt), 64'(base + 2));

        $display("[TB] load that never acks");
        runAccess(1'b0, 32'h100, 32'h0, 0, 32'h0);
        checkOne("t3_rdata", 64'(rdata_out), 64'hFFFF_FFFF);
        checkOne("t3_err", 64'(timeout_err), 64'd1);

        $display("[TB] ack on the timeout boundary wins");
        runAccess(1'b0, 32'h104, 32'h0, TIMEOUT, 32'hA5A5_0F0F);
        checkOne("t4_rdata", 64'(rdata_out), 64'hA5A5_0F0F);
        checkOne("t4_err_sticky", 64'(timeout_err), 64'd1);

        $display("[TB] back-to-back loads");
        base = m_cnt;
        runAccess(1'b0, 32'h200, 32'h0, 1, 32'h1111_2222);
        runAccess(1'b0, 32'h204, 32'h0, 1, 32'h3333_4444);
        checkOne("t5_stall_delta", 64'(stall_cnt), 64'(base + 4));

        $display("[TB] ack pulses while idle");
        idleCycles(3, 1'b1);

        $display("[TB] random transactions");
        for (int t = 0; t < 40; t++) begin
            runAccess(1'($urandom_range(0, 1)), $urandom, $urandom,
                      int'($urandom_range(0, TIMEOUT + 1)), $urandom);
            idleCycles(int'($urandom_range(0, 2)), 1'b0);
        end

        $display("[TB] reset during busy");
        applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, $urandom);
        checkOutput(1'b1, 1'b0);
        m_addr  = 32'h300;
        m_wdata = 32'h0;
        m_we    = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, $urandom);
        checkOutput(1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput(1'b0, 1'b0);
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(2, 1'b0);
        runAccess(1'b0, 32'h304, 32'h0, 2, 32'h5555_AAAA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
